// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_pkg
// Brief    : Shared constants, op encodings and FSM state type for muldiv_unit.
// Revision : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam int unsigned c_XLEN_DEFAULT = 64;
    localparam int unsigned c_MD_OP_BITS   = 3;

    localparam logic [c_MD_OP_BITS-1:0] c_MD_MUL    = 3'd0;
    localparam logic [c_MD_OP_BITS-1:0] c_MD_MULH   = 3'd1;
    localparam logic [c_MD_OP_BITS-1:0] c_MD_MULHSU = 3'd2;
    localparam logic [c_MD_OP_BITS-1:0] c_MD_MULHU  = 3'd3;
    localparam logic [c_MD_OP_BITS-1:0] c_MD_DIV    = 3'd4;
    localparam logic [c_MD_OP_BITS-1:0] c_MD_DIVU   = 3'd5;
    localparam logic [c_MD_OP_BITS-1:0] c_MD_REM    = 3'd6;
    localparam logic [c_MD_OP_BITS-1:0] c_MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // DIV and REM are the signed divides: bit2 set, bit0 clear.
    function automatic logic md_div_signed(input logic [c_MD_OP_BITS-1:0] op);
        return op[2] & ~op[0];
    endfunction

    function automatic logic md_mul_a_signed(input logic [c_MD_OP_BITS-1:0] op);
        return (op == c_MD_MULH) || (op == c_MD_MULHSU);
    endfunction

    function automatic logic md_mul_b_signed(input logic [c_MD_OP_BITS-1:0] op);
        return (op == c_MD_MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_if
// Brief    : Issue/result bundle between the E stage and muldiv_unit.
// Revision : 1.0  initial release
// ============================================================================
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = c_XLEN_DEFAULT
);
    logic                    start;
    logic                    flush;
    logic [c_MD_OP_BITS-1:0] op;
    logic                    word;
    logic [XLEN-1:0]         a;
    logic [XLEN-1:0]         b;
    logic                    busy;
    logic                    done;
    logic [XLEN-1:0]         result;

    modport master (
        output start, flush, op, word, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, word, a, b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_divider.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_divider
// Brief    : Iterative unsigned restoring divider, DIV_BITS quotient bits/cycle.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_divider #(
    parameter int unsigned W        = 64,
    parameter int unsigned DIV_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_half,
    input  logic         i_run,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_last
);
    localparam int unsigned c_STEPS = W / DIV_BITS;
    localparam int unsigned c_CNT_W = $clog2(c_STEPS);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_STEPS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_STEPS / 2 - 1);

    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_quo;
    logic [W-1:0]       r_dvs;
    logic [c_CNT_W-1:0] r_cnt;

    logic [W-1:0]       w_rem;
    logic [W-1:0]       w_quo;
    logic [W:0]         w_trial;
    logic               w_ge;

    // One cycle of the recurrence; outputs expose this cycle's result so the
    // caller can consume the final step without an extra register stage.
    always_comb begin
        w_rem   = r_rem;
        w_quo   = r_quo;
        w_trial = '0;
        w_ge    = 1'b0;
        for (int k = 0; k < int'(DIV_BITS); k++) begin
            w_trial = {w_rem, w_quo[W-1]};
            w_ge    = (w_trial >= {1'b0, r_dvs});
            w_quo   = {w_quo[W-2:0], w_ge};
            w_rem   = w_ge ? (w_trial[W-1:0] - r_dvs) : w_trial[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_dvs <= i_divisor;
            // Half-width ops park the dividend in the top half so the same
            // shift path produces a quotient in the low half.
            if (i_half) begin
                r_quo <= {i_dividend[W/2-1:0], {(W/2){1'b0}}};
                r_cnt <= c_CNT_HALF;
            end else begin
                r_quo <= i_dividend;
                r_cnt <= c_CNT_FULL;
            end
        end else if (i_run) begin
            r_rem <= w_rem;
            r_quo <= w_quo;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    assign o_quotient  = w_quo;
    assign o_remainder = w_rem;
    assign o_last      = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle RV64M multiply/divide execute unit (incl. W variants).
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN        = c_XLEN_DEFAULT,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned DIV_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam bit         c_HAS_W     = (XLEN == 64);
    localparam logic [3:0] c_MCNT_INIT = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;
    localparam logic [XLEN-1:0] c_XMIN  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic [XLEN-1:0] v;
        v       = {XLEN{x[31]}};
        v[31:0] = x;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        logic [XLEN-1:0] v;
        v       = '0;
        v[31:0] = x;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                                 input logic [c_MD_OP_BITS-1:0] op,
                                                 input logic wd);
        if (op == c_MD_MUL) begin
            return wd ? sext32(p[31:0]) : p[XLEN-1:0];
        end
        return p[2*XLEN-1:XLEN];
    endfunction

    md_state_t               r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [XLEN-1:0]         r_result;
    logic [3:0]              r_mcnt;
    logic [c_MD_OP_BITS-1:0] r_op;
    logic                    r_word;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic [2*XLEN-1:0]       r_prod;

    logic                    w_word;
    logic                    w_dsigned;
    logic [XLEN-1:0]         w_a_ext;
    logic [XLEN-1:0]         w_b_ext;
    logic [2*XLEN-1:0]       w_ma;
    logic [2*XLEN-1:0]       w_mb;
    logic [2*XLEN-1:0]       w_prod;
    logic                    w_neg_a;
    logic                    w_neg_b;
    logic [XLEN-1:0]         w_mag_a;
    logic [XLEN-1:0]         w_mag_b;
    logic                    w_b_zero;
    logic                    w_ovf;
    logic                    w_special;
    logic [XLEN-1:0]         w_a_wbit;
    logic [XLEN-1:0]         w_special_res;
    logic                    w_div_load;
    logic [XLEN-1:0]         w_quo;
    logic [XLEN-1:0]         w_rem;
    logic                    w_last;
    logic [XLEN-1:0]         w_q_s;
    logic [XLEN-1:0]         w_r_s;
    logic [XLEN-1:0]         w_div_sel;
    logic [XLEN-1:0]         w_div_fin;

    // Operand preparation from the issuing instruction.
    always_comb begin
        w_word    = bus.word & c_HAS_W;
        w_dsigned = md_div_signed(bus.op);
        w_a_ext   = bus.a;
        w_b_ext   = bus.b;
        if (w_word) begin
            w_a_ext = w_dsigned ? sext32(bus.a[31:0]) : zext32(bus.a[31:0]);
            w_b_ext = w_dsigned ? sext32(bus.b[31:0]) : zext32(bus.b[31:0]);
        end

        // Sign-extending to 2*XLEN makes a plain modular product equal the
        // low 2*XLEN bits of the signed/unsigned product for every mix.
        w_ma   = {{XLEN{md_mul_a_signed(bus.op) & w_a_ext[XLEN-1]}}, w_a_ext};
        w_mb   = {{XLEN{md_mul_b_signed(bus.op) & w_b_ext[XLEN-1]}}, w_b_ext};
        w_prod = w_ma * w_mb;

        w_neg_a = w_dsigned & w_a_ext[XLEN-1];
        w_neg_b = w_dsigned & w_b_ext[XLEN-1];
        w_mag_a = w_neg_a ? -w_a_ext : w_a_ext;
        w_mag_b = w_neg_b ? -w_b_ext : w_b_ext;

        w_b_zero = (w_b_ext == '0);
        if (w_word) begin
            w_ovf = w_dsigned && (bus.a[31:0] == 32'h8000_0000) && (bus.b[31:0] == 32'hFFFF_FFFF);
        end else begin
            w_ovf = w_dsigned && (bus.a == c_XMIN) && (bus.b == '1);
        end
        w_special = w_b_zero | w_ovf;

        w_a_wbit = w_word ? sext32(bus.a[31:0]) : bus.a;
        if (w_b_zero) begin
            w_special_res = bus.op[1] ? w_a_wbit : '1;
        end else begin
            w_special_res = bus.op[1] ? '0 : w_a_wbit;
        end
    end

    assign w_div_load = (r_state == MD_IDLE || r_state == MD_DONE) && bus.start &&
                        !bus.flush && bus.op[2] && !w_special;

    muldiv_divider #(
        .W        (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_divider (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_div_load),
        .i_half      (w_word),
        .i_run       (r_state == MD_DIV),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_last      (w_last)
    );

    // Signs go back on in the same cycle the last quotient bits appear.
    always_comb begin
        w_q_s     = r_neg_q ? -w_quo : w_quo;
        w_r_s     = r_neg_r ? -w_rem : w_rem;
        w_div_sel = r_op[1] ? w_r_s : w_q_s;
        w_div_fin = r_word ? sext32(w_div_sel[31:0]) : w_div_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= MD_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_mcnt   <= '0;
            r_op     <= c_MD_MUL;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_prod   <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= MD_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    MD_IDLE, MD_DONE: begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                        if (bus.start) begin
                            r_op    <= bus.op;
                            r_word  <= w_word;
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
                            r_prod  <= w_prod;
                            if (!bus.op[2]) begin
                                if (MUL_LATENCY == 1) begin
                                    r_state  <= MD_DONE;
                                    r_done   <= 1'b1;
                                    r_result <= mul_pick(w_prod, bus.op, w_word);
                                end else begin
                                    r_state <= MD_MUL;
                                    r_busy  <= 1'b1;
                                    r_mcnt  <= c_MCNT_INIT;
                                end
                            end else if (w_special) begin
                                r_state  <= MD_DONE;
                                r_done   <= 1'b1;
                                r_result <= w_special_res;
                            end else begin
                                r_state <= MD_DIV;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    MD_MUL: begin
                        if (r_mcnt == 4'd0) begin
                            r_state  <= MD_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= mul_pick(r_prod, r_op, r_word);
                        end else begin
                            r_mcnt <= r_mcnt - 4'd1;
                        end
                    end
                    MD_DIV: begin
                        if (w_last) begin
                            r_state  <= MD_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_div_fin;
                        end
                    end
                    default: begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed vector bench for muldiv_unit (DIV_BITS=1/MUL_LATENCY=3
//            and DIV_BITS=4/MUL_LATENCY=1 instances driven in parallel).
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          special;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        t_start;
    logic        t_flush;
    logic        t_word;
    logic [2:0]  t_op;
    logic [63:0] t_a;
    logic [63:0] t_b;

    int checks = 0;
    int errors = 0;

    muldiv_unit_if #(.XLEN(64)) bus1 ();
    muldiv_unit_if #(.XLEN(64)) bus4 ();

    assign bus1.start = t_start;
    assign bus1.flush = t_flush;
    assign bus1.op    = t_op;
    assign bus1.word  = t_word;
    assign bus1.a     = t_a;
    assign bus1.b     = t_b;
    assign bus4.start = t_start;
    assign bus4.flush = t_flush;
    assign bus4.op    = t_op;
    assign bus4.word  = t_word;
    assign bus4.a     = t_a;
    assign bus4.b     = t_b;

    muldiv_unit #(.XLEN(64), .MUL_LATENCY(3), .DIV_BITS(1)) u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    muldiv_unit #(.XLEN(64), .MUL_LATENCY(1), .DIV_BITS(4)) u_dut4 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic word, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] exp, input bit sp,
                                input string nm);
        vec_t v;
        v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp; v.special = sp; v.name = nm;
        return v;
    endfunction

    function automatic int exp_lat(input vec_t v, input int mlat, input int db);
        if (!v.op[2]) return mlat;
        if (v.special) return 1;
        return (v.word ? 32 : 64) / db + 1;
    endfunction

    // Issue one op to both instances and check busy/done every cycle plus the result.
    task automatic run_vec(input vec_t v, input bit poke);
        int e1, e4, kmax, bad1, bad4;
        logic [63:0] r1, r4;
        e1 = exp_lat(v, 3, 1);
        e4 = exp_lat(v, 1, 4);
        kmax = ((e1 > e4) ? e1 : e4) + 1;
        bad1 = 0; bad4 = 0; r1 = 'x; r4 = 'x;
        @(posedge clk); #1;
        t_op = v.op; t_word = v.word; t_a = v.a; t_b = v.b; t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            if (poke && k == 5) begin
                t_start = 1'b1; t_op = c_MD_MUL; t_word = 1'b0; t_a = 64'd1; t_b = 64'd1;
            end else if (poke && k == 6) begin
                t_start = 1'b0; t_op = v.op; t_word = v.word; t_a = v.a; t_b = v.b;
            end
            if (bus1.busy !== ((k < e1) ? 1'b1 : 1'b0) || bus1.done !== ((k == e1) ? 1'b1 : 1'b0)) bad1++;
            if (bus4.busy !== ((k < e4) ? 1'b1 : 1'b0) || bus4.done !== ((k == e4) ? 1'b1 : 1'b0)) bad4++;
            if (k == e1) r1 = bus1.result;
            if (k == e4) r4 = bus4.result;
            @(posedge clk); #1;
        end
        chk({v.name, " timing d1"}, 64'(bad1), 64'd0);
        chk({v.name, " timing d4"}, 64'(bad4), 64'd0);
        chk({v.name, " result d1"}, r1, v.exp);
        chk({v.name, " result d4"}, r4, v.exp);
    endtask

    task automatic watch_quiet(input int n, output int dones);
        dones = 0;
        for (int k = 0; k < n; k++) begin
            if (bus1.done === 1'b1 || bus4.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[$];
    int   nd;

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        t_start = 1'b0; t_flush = 1'b0; t_word = 1'b0; t_op = '0; t_a = '0; t_b = '0;

        vecs.push_back(mk(c_MD_MUL,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0, "mul"));
        vecs.push_back(mk(c_MD_MULHU,  0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulhu"));
        vecs.push_back(mk(c_MD_MULHSU, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, "mulhsu"));
        vecs.push_back(mk(c_MD_MULH,   0, '1, '1, 64'd0, 0, "mulh_m1"));
        vecs.push_back(mk(c_MD_MULH,   0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 0, "mulh_2p64"));
        vecs.push_back(mk(c_MD_MUL,    1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulw"));
        vecs.push_back(mk(c_MD_DIV,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, "div_m7_2"));
        vecs.push_back(mk(c_MD_REM,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, "rem_m7_2"));
        vecs.push_back(mk(c_MD_DIV,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 0, "div_7_m2"));
        vecs.push_back(mk(c_MD_REM,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, "rem_7_m2"));
        vecs.push_back(mk(c_MD_DIVU,   0, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 0, "divu_big"));
        vecs.push_back(mk(c_MD_REMU,   0, '1, 64'h10, 64'hF, 0, "remu_big"));
        vecs.push_back(mk(c_MD_DIV,    0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 0, "div_min_2"));
        vecs.push_back(mk(c_MD_DIVU,   0, 64'd5, 64'd0, '1, 1, "divu_by0"));
        vecs.push_back(mk(c_MD_REMU,   0, 64'd5, 64'd0, 64'd5, 1, "remu_by0"));
        vecs.push_back(mk(c_MD_DIV,    0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_ovf"));
        vecs.push_back(mk(c_MD_REM,    0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem_ovf"));
        vecs.push_back(mk(c_MD_DIV,    1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf"));
        vecs.push_back(mk(c_MD_REM,    1, 64'h0000_0000_8000_0000, '1, 64'd0, 1, "remw_ovf"));
        vecs.push_back(mk(c_MD_DIVU,   1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0, "divuw"));
        vecs.push_back(mk(c_MD_REM,    1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 0, "remw_m7_2"));
        vecs.push_back(mk(c_MD_DIV,    1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0001_0000_0000, '1, 1, "divw_by0"));
        vecs.push_back(mk(c_MD_REMU,   1, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000,
                          64'hFFFF_FFFF_8000_0005, 1, "remuw_by0"));

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy d1", 64'(bus1.busy), 64'd0);
        chk("reset done d1", 64'(bus1.done), 64'd0);
        chk("reset result d1", bus1.result, 64'd0);
        chk("reset busy d4", 64'(bus4.busy), 64'd0);
        chk("reset result d4", bus4.result, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], 1'b0);

        // A start arriving mid-divide must not disturb the op in flight.
        run_vec(mk(c_MD_DIVU, 0, 64'd100, 64'd7, 64'd14, 0, "divu_poke"), 1'b1);

        // Back-to-back issue in the done cycle.
        @(posedge clk); #1;
        t_op = c_MD_DIVU; t_word = 1'b0; t_a = 64'd5; t_b = 64'd0; t_start = 1'b1;
        @(posedge clk); #1;
        chk("b2b first done d1", 64'(bus1.done), 64'd1);
        chk("b2b first result d4", bus4.result, '1);
        t_op = c_MD_REMU;
        @(posedge clk); #1;
        chk("b2b second done d1", 64'(bus1.done), 64'd1);
        chk("b2b second result d1", bus1.result, 64'd5);
        chk("b2b second result d4", bus4.result, 64'd5);
        t_start = 1'b0;
        @(posedge clk); #1;
        chk("b2b done drops", 64'(bus1.done | bus4.done), 64'd0);

        // Flush a divide at S+10, then flush+start together.
        t_op = c_MD_DIV; t_a = 64'hFFFF_FFFF_FFFF_FFF9; t_b = 64'd2; t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        t_flush = 1'b1;
        @(posedge clk); #1;
        t_flush = 1'b0;
        chk("flush busy d1", 64'(bus1.busy), 64'd0);
        chk("flush busy d4", 64'(bus4.busy), 64'd0);
        t_op = c_MD_DIVU; t_a = 64'd100; t_b = 64'd7; t_start = 1'b1; t_flush = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0; t_flush = 1'b0;
        chk("flush+start busy", 64'(bus1.busy | bus4.busy), 64'd0);
        watch_quiet(70, nd);
        chk("flush no done", 64'(nd), 64'd0);
        chk("flush result held d1", bus1.result, 64'd5);
        chk("flush result held d4", bus4.result, 64'd5);

        // Asynchronous reset mid-operation.
        t_op = c_MD_DIVU; t_a = 64'd100; t_b = 64'd7; t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 64'(bus1.busy | bus4.busy), 64'd0);
        chk("async rst done", 64'(bus1.done | bus4.done), 64'd0);
        chk("async rst result d1", bus1.result, 64'd0);
        chk("async rst result d4", bus4.result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        watch_quiet(70, nd);
        chk("post rst no done", 64'(nd), 64'd0);

        run_vec(mk(c_MD_MUL, 0, 64'd6, 64'd7, 64'd42, 0, "mul_after_rst"), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
